spi_slave: RTL and testbench

//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), the far end of the core's SPI initiator.

---
 rtl/spi_slave_if.sv | 41 ++++
 rtl/spi_slave.sv | 139 +++++++++++++
 tb/tb_spi_slave.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// ============================================================================
// spi_slave_if : CPU-side and SPI pin bundle for spi_slave (optional SPI_SLAVE_UNDERRUN_EN)
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_slave_if;
  logic       tx_strobe;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx_strobe;
  logic       tx_empty;
  logic       active;
  logic       spi_sck;
  logic       spi_ss_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
`endif

  modport slave (
    input  tx_strobe, din, spi_sck, spi_ss_n, spi_mosi,
`ifdef SPI_SLAVE_UNDERRUN_EN
    output tx_underrun,
`endif
    output dout, rx_strobe, tx_empty, active, spi_miso, spi_miso_oe
  );

  modport master (
    output tx_strobe, din, spi_sck, spi_ss_n, spi_mosi,
`ifdef SPI_SLAVE_UNDERRUN_EN
    input  tx_underrun,
`endif
    input  dout, rx_strobe, tx_empty, active, spi_miso, spi_miso_oe
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// spi_slave : oversampled SPI mode-0 responder, macro SPI_SLAVE_UNDERRUN_EN adds tx_underrun
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] ss_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sck_hist;
  logic                   ss_hist;

  // SS chain resets low so a select still held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_pipe  <= '0;
      ss_pipe   <= '0;
      mosi_pipe <= '0;
      sck_hist  <= 1'b0;
      ss_hist   <= 1'b0;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0],  bus.spi_sck};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0],   bus.spi_ss_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.spi_mosi};
      sck_hist  <= sck_pipe[SYNC_STAGES-1];
      ss_hist   <= ss_pipe[SYNC_STAGES-1];
    end
  end

  logic sck_sync, ss_sync, mosi_sync;
  logic sck_rise, sck_fall, ss_fall, ss_rise;

  assign sck_sync  = sck_pipe[SYNC_STAGES-1];
  assign ss_sync   = ss_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
  assign sck_rise  = sck_sync  & ~sck_hist;
  assign sck_fall  = ~sck_sync & sck_hist;
  assign ss_fall   = ~ss_sync  & ss_hist;
  assign ss_rise   = ss_sync   & ~ss_hist;

  logic       sel_active;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] holding;
  logic       hold_empty;
  logic [7:0] rx_data;
  logic       rx_pulse;

  logic       boundary_load;
  logic       do_load;
  logic [7:0] rx_next;

  assign boundary_load = sel_active & sck_fall & (bit_cnt == 3'd0) & ~ss_fall & ~ss_rise;
  assign do_load       = ss_fall | boundary_load;
  assign rx_next       = {rx_shift, mosi_sync};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_active <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= IDLE_BYTE;
      holding    <= 8'd0;
      hold_empty <= 1'b1;
      rx_data    <= 8'd0;
      rx_pulse   <= 1'b0;
    end else begin
      rx_pulse <= 1'b0;

      // Select edges take priority over any SCK edge seen in the same cycle.
      if (ss_fall) begin
        sel_active <= 1'b1;
        bit_cnt    <= 3'd0;
        rx_shift   <= 7'd0;
      end else if (ss_rise) begin
        sel_active <= 1'b0;
        bit_cnt    <= 3'd0;
      end else if (sel_active) begin
        if (sck_rise) begin
          rx_shift <= rx_next[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data  <= rx_next;
            rx_pulse <= 1'b1;
          end
        end else if (sck_fall && bit_cnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
      end

      // A CPU write landing on a load cycle either refills holding or bypasses straight to the shifter.
      if (do_load) begin
        if (!hold_empty) begin
          tx_shift <= holding;
          if (bus.tx_strobe) holding <= bus.din;
          else               hold_empty <= 1'b1;
        end else begin
          tx_shift <= bus.tx_strobe ? bus.din : IDLE_BYTE;
        end
      end else if (bus.tx_strobe) begin
        holding    <= bus.din;
        hold_empty <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            underrun <= 1'b0;
    else if (boundary_load && hold_empty) underrun <= 1'b1;
    else if (bus.tx_strobe)               underrun <= 1'b0;
  end

  assign bus.tx_underrun = underrun;
`endif

  assign bus.dout        = rx_data;
  assign bus.rx_strobe   = rx_pulse;
  assign bus.tx_empty    = hold_empty;
  assign bus.active      = sel_active;
  assign bus.spi_miso    = sel_active ? tx_shift[7] : 1'b1;
  assign bus.spi_miso_oe = sel_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// tb_spi_slave : self-checking bench for spi_slave (vector table + corner sequences)
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave;
  localparam int         SYNC = 2;
  localparam logic [7:0] IDLE = 8'hFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_if sif();

  spi_slave #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always @(negedge clk)
    if (!reset && sif.rx_strobe) rx_q.push_back(sif.dout);

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic [7:0] mosi;
    logic [7:0] miso;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] v);
    @(negedge clk);
    sif.tx_strobe = 1'b1;
    sif.din       = v;
    @(negedge clk);
    sif.tx_strobe = 1'b0;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    sif.spi_ss_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic ss_end();
    @(negedge clk);
    sif.spi_ss_n = 1'b1;
    wait_clk(6);
  endtask

  // Mode-0 master: 5-clock low and high phases, MISO sampled just before the rising edge.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, input logic mid_wr,
                          input logic [7:0] mid_val, output logic [7:0] miso);
    miso = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sif.spi_mosi = mosi[7-i];
      wait_clk(4);
      miso = {miso[6:0], sif.spi_miso};
      sif.spi_sck = 1'b1;
      if (mid_wr && i == 3) begin
        @(negedge clk);
        sif.tx_strobe = 1'b1;
        sif.din       = mid_val;
        @(negedge clk);
        sif.tx_strobe = 1'b0;
        wait_clk(3);
      end else begin
        wait_clk(5);
      end
      sif.spi_sck = 1'b0;
    end
    wait_clk(5);
  endtask

  task automatic sb_drain(input string name);
    int n;
    n = exp_q.size();
    chk({name, "_count"}, rx_q.size(), n);
    while (exp_q.size() > 0 && rx_q.size() > 0)
      chk({name, "_dout"}, rx_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    sif.spi_sck   = 1'b0;
    sif.spi_ss_n  = 1'b1;
    sif.spi_mosi  = 1'b0;
    sif.tx_strobe = 1'b0;
    sif.din       = 8'd0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 8'h5A, 8'h80, 8'h5A};
    vecs[4] = '{1'b0, 8'h12, 8'hC3, 8'hFF};

    wait_clk(3);
    chk("rst_dout",     sif.dout, 8'h00);
    chk("rst_rxstb",    sif.rx_strobe, 1'b0);
    chk("rst_tx_empty", sif.tx_empty, 1'b1);
    chk("rst_active",   sif.active, 1'b0);
    chk("rst_miso",     sif.spi_miso, 1'b1);
    chk("rst_oe",       sif.spi_miso_oe, 1'b0);
    reset = 1'b0;
    wait_clk(8);

    // Two-byte transfer with nothing written: idle bytes out.
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("t2_underrun_rst", sif.tx_underrun, 1'b0);
`endif
    ss_begin();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    spi_bits(8'h01, 8, 1'b0, 8'h00, m);
    chk("t2_miso0", m, 8'hFF);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("t2_underrun_b1", sif.tx_underrun, 1'b1);
`endif
    spi_bits(8'h80, 8, 1'b0, 8'h00, m);
    chk("t2_miso1", m, 8'hFF);
    ss_end();
    sb_drain("t2");

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr) begin
        tx_write(vecs[v].din);
`ifdef SPI_SLAVE_UNDERRUN_EN
        chk("vec_underrun_clr", sif.tx_underrun, 1'b0);
`endif
      end
      chk("vec_empty_pre", sif.tx_empty, !vecs[v].wr);
      ss_begin();
      chk("vec_empty_post", sif.tx_empty, 1'b1);
      chk("vec_active", sif.active, 1'b1);
      chk("vec_oe", sif.spi_miso_oe, 1'b1);
      exp_q.push_back(vecs[v].mosi);
      spi_bits(vecs[v].mosi, 8, 1'b0, 8'h00, m);
      chk("vec_miso", m, vecs[v].miso);
      ss_end();
      sb_drain("vec");
      chk("vec_idle_miso", sif.spi_miso, 1'b1);
`ifdef SPI_SLAVE_UNDERRUN_EN
      chk("vec_underrun_set", sif.tx_underrun, 1'b1);
`endif
    end

    // Write during byte 1 feeds byte 2; back-to-back writes keep only the last.
    tx_write(8'h11);
    ss_begin();
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'h0C);
    spi_bits(8'hC0, 8, 1'b1, 8'h22, m);
    chk("t3_byte1", m, 8'h11);
    spi_bits(8'h0C, 8, 1'b0, 8'h00, m);
    chk("t3_byte2", m, 8'h22);
    ss_end();
    sb_drain("t3a");
    tx_write(8'h33);
    tx_write(8'h44);
    ss_begin();
    chk("t3_empty", sif.tx_empty, 1'b1);
    exp_q.push_back(8'hE7);
    spi_bits(8'hE7, 8, 1'b0, 8'h00, m);
    chk("t3_overwrite", m, 8'h44);
    ss_end();
    sb_drain("t3b");

    // Select released after 5 bits: partial byte dropped.
    ss_begin();
    spi_bits(8'hA8, 5, 1'b0, 8'h00, m);
    ss_end();
    sb_drain("t4_partial");
    chk("t4_active", sif.active, 1'b0);
    chk("t4_miso", sif.spi_miso, 1'b1);
    ss_begin();
    exp_q.push_back(8'h5A);
    spi_bits(8'h5A, 8, 1'b0, 8'h00, m);
    chk("t4_miso_full", m, 8'hFF);
    ss_end();
    sb_drain("t4_full");

    // CPU write in the exact cycle the select-fall load happens, holding empty.
    @(negedge clk);
    sif.spi_ss_n = 1'b0;
    wait_clk(SYNC);
    sif.tx_strobe = 1'b1;
    sif.din       = 8'h77;
    @(negedge clk);
    sif.tx_strobe = 1'b0;
    wait_clk(4);
    chk("t5_empty", sif.tx_empty, 1'b1);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("t5_underrun_clr", sif.tx_underrun, 1'b0);
`endif
    exp_q.push_back(8'h96);
    spi_bits(8'h96, 8, 1'b0, 8'h00, m);
    chk("t5_bypass", m, 8'h77);
    ss_end();
    sb_drain("t5");

    // Reset in the middle of bit 4 with a byte pending.
    ss_begin();
    spi_bits(8'hFF, 4, 1'b0, 8'h00, m);
    tx_write(8'h3E);
    chk("t6_pending", sif.tx_empty, 1'b0);
    @(negedge clk);
    sif.spi_sck = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    #1;
    chk("t6_dout",     sif.dout, 8'h00);
    chk("t6_rxstb",    sif.rx_strobe, 1'b0);
    chk("t6_tx_empty", sif.tx_empty, 1'b1);
    chk("t6_active",   sif.active, 1'b0);
    chk("t6_miso",     sif.spi_miso, 1'b1);
    chk("t6_oe",       sif.spi_miso_oe, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("t6_underrun", sif.tx_underrun, 1'b0);
`endif
    wait_clk(3);
    sif.spi_sck = 1'b0;
    reset = 1'b0;
    wait_clk(8);
    chk("t6_no_reselect", sif.active, 1'b0);
    sif.spi_ss_n = 1'b1;
    wait_clk(6);
    rx_q.delete();
    ss_begin();
    exp_q.push_back(8'hC3);
    spi_bits(8'hC3, 8, 1'b0, 8'h00, m);
    chk("t6_miso", m, 8'hFF);
    ss_end();
    sb_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
